// File: rtl/nroot_seq_ctrl.sv
// Sequencer for the Method-1 n-th root datapath: drives the factor/root stage, then loops a shared sqrt unit.
// Optional NROOT_TIMEOUT_EN adds a per-pass sq_done watchdog that ends the operation with a qNaN error.
module nroot_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] fracin,
  input  logic             check,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [23:0]      factor,
  output logic [WIDTH-1:0] fr_fracin,
  output logic             fr_check,
  output logic             fr_checkin,
  output logic             fr_checkBin,
  input  logic [23:0]      fr_factor,
  input  logic [CNT_W-1:0] fr_root,
  input  logic             fr_over,
  output logic             sq_start,
  output logic [WIDTH-1:0] sq_in,
  input  logic             sq_done,
  input  logic [WIDTH-1:0] sq_out
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [WIDTH-1:0] VAL_INF  = WIDTH'(32'h7F80_0000);
  localparam logic [WIDTH-1:0] VAL_QNAN = WIDTH'(32'h7FC0_0000);

  logic [2:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

`ifdef NROOT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
  logic            to_flag;
`endif

  assign fr_checkin  = 1'b0;
  assign fr_checkBin = 1'b0;
  // acc holds the value for the next pass, so it doubles as the sqrt operand
  assign sq_in       = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sq_start  <= 1'b0;
      result    <= '0;
      factor    <= '0;
      fr_fracin <= '0;
      fr_check  <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
`ifdef NROOT_TIMEOUT_EN
      wd        <= '0;
      to_flag   <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      sq_start <= 1'b0;
      // busy spans the done cycle, so a start coinciding with done is dropped
      if (done) busy <= 1'b0;
      case (state)
        S_IDLE: if (start && !busy) begin
          acc       <= fracin;
          fr_fracin <= fracin;
          fr_check  <= check;
          busy      <= 1'b1;
          state     <= S_SETUP;
`ifdef NROOT_TIMEOUT_EN
          to_flag   <= 1'b0;
`endif
        end
        S_SETUP: begin
          factor <= fr_factor;
          cnt    <= fr_root;
          if (fr_over)              state <= S_ERR;
          else if (fr_root == '0)   state <= S_DONE;
          else begin
            sq_start <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef NROOT_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        S_WAIT: begin
          if (sq_done) begin
            acc <= sq_out;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= S_DONE;
            else begin
              sq_start <= 1'b1;
              state    <= S_ISSUE;
            end
          end
`ifdef NROOT_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT)) begin
            to_flag <= 1'b1;
            state   <= S_ERR;
          end else wd <= wd + 1'b1;
`endif
        end
        S_DONE: begin
          done   <= 1'b1;
          result <= acc;
          state  <= S_IDLE;
        end
        S_ERR: begin
          done   <= 1'b1;
          err    <= 1'b1;
`ifdef NROOT_TIMEOUT_EN
          result <= to_flag ? VAL_QNAN : VAL_INF;
`else
          result <= VAL_INF;
`endif
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nroot_seq_ctrl.sv
// Randomized bench for nroot_seq_ctrl: factor-stage and sqrt stubs, pass-count/latency/result model.
module tb_nroot_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] fracin = '0;
  logic        check = 1'b0;
  logic        busy, done, err;
  logic [31:0] result;
  logic [23:0] factor;
  logic [31:0] fr_fracin;
  logic        fr_check, fr_checkin, fr_checkBin;
  logic [23:0] fr_factor = '0;
  logic [4:0]  fr_root = '0;
  logic        fr_over = 1'b0;
  logic        sq_start;
  logic [31:0] sq_in;
  logic        sq_done = 1'b0;
  logic [31:0] sq_out = '0;

  int n_chk = 0, n_err = 0;
  int lat_cfg = 3;
  bit hang = 0;
  int inj_req = 0, inj_ack = 0;
  int nstart = 0, rem = 0;
  logic [31:0] pend;

  nroot_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fracin(fracin), .check(check),
    .busy(busy), .done(done), .err(err), .result(result), .factor(factor),
    .fr_fracin(fr_fracin), .fr_check(fr_check), .fr_checkin(fr_checkin),
    .fr_checkBin(fr_checkBin), .fr_factor(fr_factor), .fr_root(fr_root),
    .fr_over(fr_over), .sq_start(sq_start), .sq_in(sq_in), .sq_done(sq_done),
    .sq_out(sq_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sq_f(input logic [31:0] x);
    return {x[30:0], x[31]} ^ 32'h5A3C_0F01;
  endfunction

  // sqrt stub: sq_done lands lat_cfg cycles after the cycle sq_start is seen
  always @(negedge clk) begin
    if (sq_done) sq_done = 1'b0;
    if (rem > 0) begin
      rem--;
      if (rem == 0 && !hang) begin sq_done = 1'b1; sq_out = pend; end
    end
    if (inj_req != inj_ack) begin sq_done = 1'b1; sq_out = 32'hDEAD_BEEF; inj_ack = inj_req; end
    if (sq_start) begin nstart++; rem = lat_cfg; pend = sq_f(sq_in); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic [31:0] op, input logic ck, input int root,
                         input bit over, input int lat, input bit poke, input bit to_case);
    logic [31:0] exp_res, v;
    logic [23:0] fac;
    int exp_cyc, exp_ns, ns0, k, lim;
    bit got;
    fac = 24'($urandom);
    fr_factor = fac; fr_root = 5'(root); fr_over = over; lat_cfg = lat;
    v = op;
    for (int i = 0; i < root; i++) v = sq_f(v);
    if (to_case) begin exp_cyc = 2 + 1 + 64 + 1; exp_res = 32'h7FC0_0000; exp_ns = 1; end
    else if (over) begin exp_cyc = 2; exp_res = 32'h7F80_0000; exp_ns = 0; end
    else begin
      exp_cyc = 2 + root * (lat + 1); exp_res = v; exp_ns = root;
    end
    ns0 = nstart;
    @(negedge clk); fracin = op; check = ck; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; fracin = $urandom; check = ~ck;
    chk("busy_on_accept", 32'(busy), 32'd1);
    chk("fr_fracin", fr_fracin, op);
    chk("fr_check", 32'(fr_check), 32'(ck));
    k = 0; got = 0; lim = exp_cyc + 10;
    while (k < lim && !got) begin
      @(posedge clk); #1; k++;
      if (poke && k == 6) begin start = 1'b1; fracin = 32'h1234_5678; end
      if (poke && k == 7) start = 1'b0;
      if (done) got = 1;
    end
    if (!got) begin n_chk++; n_err++; $display("FAIL done_timeout: got no done expected cycle %0d", exp_cyc); end
    chk("done_cycle", 32'(k), 32'(exp_cyc));
    chk("err", 32'(err), 32'(over | to_case));
    chk("result", result, exp_res);
    chk("factor", 32'(factor), 32'(fac));
    chk("sq_start_count", 32'(nstart - ns0), 32'(exp_ns));
    start = 1'b1;  // coincides with done: must be dropped
    @(posedge clk); #1; start = 1'b0;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_pulse_width", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("start_on_done_ignored", 32'(busy), 32'd0);
    chk("result_held", result, exp_res);
  endtask

  initial begin
    bit seen;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sq_start", 32'(sq_start), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_factor", 32'(factor), 32'd0);
    chk("rst_sq_in", sq_in, 32'd0);
    chk("rst_fr_fracin", fr_fracin, 32'd0);
    chk("fr_checkin", 32'({fr_checkin, fr_checkBin}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // stray sq_done while idle
    inj_req++;
    repeat (3) @(negedge clk);
    chk("stray_done_busy", 32'(busy), 32'd0);
    chk("stray_done_done", 32'(done), 32'd0);

    run_txn(32'h3F80_0000, 1'b1, 5, 1'b0, 3, 1'b0, 1'b0);
    run_txn(32'h4B80_0000, 1'b0, 3, 1'b1, 3, 1'b0, 1'b0);
    run_txn(32'h4120_0000, 1'b0, 0, 1'b0, 2, 1'b0, 1'b0);
    run_txn(32'h3F80_0000, 1'b1, 5, 1'b0, 3, 1'b1, 1'b0);

    // reset during the third WAIT (sq_start at 1,5,9; WAIT 10..12)
    fr_factor = 24'hABCDEF; fr_root = 5'd5; fr_over = 1'b0; lat_cfg = 3;
    @(negedge clk); fracin = 32'h4000_0000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (11) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("mid_rst_sq_start", 32'(sq_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (done || busy || sq_start) seen = 1; end
    chk("late_sq_done_ignored", 32'(seen), 32'd0);
    run_txn(32'h4080_0000, 1'b1, 2, 1'b0, 1, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      int r, l;
      bit ov, pk;
      r  = $urandom_range(0, 6);
      l  = $urandom_range(1, 4);
      ov = ($urandom_range(0, 5) == 0);
      pk = (r >= 2) && !ov;
      run_txn($urandom, 1'($urandom), r, ov, l, pk, 1'b0);
    end

`ifdef NROOT_TIMEOUT_EN
    hang = 1;
    run_txn(32'h3F80_0000, 1'b1, 4, 1'b0, 3, 1'b0, 1'b1);
    hang = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
